// File: rtl/axis_byte_to_word.sv
// rtl/axis_byte_to_word.sv - packs an AXI-stream byte stream into MSB-first words
// Frame tlast/tuser carried through; a frame ending mid-word is zero-padded and flagged.
module axis_byte_to_word #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                input_axis_tdata,
  input  logic                                 input_axis_tvalid,
  output logic                                 input_axis_tready,
  input  logic                                 input_axis_tlast,
  input  logic                                 input_axis_tuser,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] output_axis_tdata,
  output logic                                 output_axis_tvalid,
  input  logic                                 output_axis_tready,
  output logic                                 output_axis_tlast,
  output logic                                 output_axis_tuser,
  output logic                                 short_word
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = BYTES_PER_WORD;
  localparam int WW = W * N;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [CW-1:0] byte_cnt;
  logic [WW-1:0] accum;
  logic          sticky_err;

  logic          accept;
  logic          final_byte;
  logic          complete;
  logic          is_short;
  logic [WW-1:0] byte_ext;
  logic [WW-1:0] word_next;

  // A word may be loaded whenever the output slot is empty or draining this cycle.
  assign input_axis_tready = ~output_axis_tvalid | output_axis_tready;
  assign accept            = input_axis_tvalid & input_axis_tready;
  assign final_byte        = (byte_cnt == LAST_IDX);
  assign complete          = accept & (final_byte | input_axis_tlast);
  assign is_short          = input_axis_tlast & ~final_byte;

  // Lower bytes of accum are always zero ahead of the fill point, which gives the padding.
  always_comb begin
    byte_ext          = '0;
    byte_ext[W-1:0]   = input_axis_tdata;
    word_next         = accum | (byte_ext << (W * (N - 1 - int'(byte_cnt))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt           <= '0;
      accum              <= '0;
      sticky_err         <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
      short_word         <= 1'b0;
    end else begin
      short_word <= 1'b0;
      if (output_axis_tvalid && output_axis_tready) begin
        output_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          output_axis_tdata  <= word_next;
          output_axis_tlast  <= input_axis_tlast;
          output_axis_tuser  <= sticky_err | input_axis_tuser | is_short;
          output_axis_tvalid <= 1'b1;
          short_word         <= is_short;
          byte_cnt           <= '0;
          accum              <= '0;
          sticky_err         <= 1'b0;
        end else begin
          byte_cnt   <= byte_cnt + 1'b1;
          accum      <= word_next;
          sticky_err <= sticky_err | input_axis_tuser;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_to_word.sv
// tb/tb_axis_byte_to_word.sv - scoreboard bench for axis_byte_to_word (N=2)
module tb_axis_byte_to_word;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tlast = 1'b0;
  logic        in_tuser = 1'b0;
  logic [15:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tlast;
  logic        out_tuser;
  logic        short_word;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        user;
    logic        sw;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  axis_byte_to_word #(.DATA_WIDTH(8), .BYTES_PER_WORD(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_tdata),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tready  (in_tready),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .output_axis_tdata  (out_tdata),
    .output_axis_tvalid (out_tvalid),
    .output_axis_tready (out_tready),
    .output_axis_tlast  (out_tlast),
    .output_axis_tuser  (out_tuser),
    .short_word         (short_word)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic l, input logic u, input logic s);
    exp_t e;
    e.data = d; e.last = l; e.user = u; e.sw = s;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send(input logic [7:0] d, input logic l, input logic u);
    bit done;
    done      = 1'b0;
    in_tdata  = d;
    in_tvalid = 1'b1;
    in_tlast  = l;
    in_tuser  = u;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_tready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 1, 0);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
  endtask

  // Monitor: captures short_word on the first cycle each word is presented, compares on handshake.
  logic prev_tvalid = 1'b0;
  logic prev_hs     = 1'b0;
  logic sw_cap      = 1'b0;
  logic first_cyc;
  exp_t got;

  always @(negedge clk) begin
    if (rst) begin
      prev_tvalid = 1'b0;
      prev_hs     = 1'b0;
    end else begin
      first_cyc = out_tvalid && (!prev_tvalid || prev_hs);
      if (first_cyc) sw_cap = short_word;
      else check("short_word_spurious", short_word, 0);
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_tdata, 0);
        end else begin
          got = exp_q.pop_front();
          check("word_tdata", out_tdata, got.data);
          check("word_tlast", out_tlast, got.last);
          check("word_tuser", out_tuser, got.user);
          check("word_short", sw_cap, got.sw);
        end
      end
      prev_tvalid = out_tvalid;
      prev_hs     = out_tvalid && out_tready;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tdata", out_tdata, 0);
    check("rst_tlast", out_tlast, 0);
    check("rst_tuser", out_tuser, 0);
    check("rst_short", short_word, 0);
    check("rst_in_tready", in_tready, 1);
    rst = 1'b0;

    // Basic pair with 1-clk latency
    expect_word(16'hA53C, 1, 0, 0);
    send(8'hA5, 0, 0);
    check("no_early_valid", out_tvalid, 0);
    send(8'h3C, 1, 0);
    check("latency_valid", out_tvalid, 1);

    // Two words back-to-back
    expect_word(16'h1122, 0, 0, 0);
    expect_word(16'h3344, 1, 0, 0);
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    check("b2b_valid_held", out_tvalid, 0);
    send(8'h44, 1, 0);

    // Short frame: single byte with tlast
    expect_word(16'h7E00, 1, 1, 1);
    send(8'h7E, 1, 0);
    check("short_pulse_hi", short_word, 1);
    @(posedge clk); #1;
    check("short_pulse_lo", short_word, 0);

    // Error flag on first byte only affects its own word
    expect_word(16'h0102, 0, 1, 0);
    expect_word(16'h0304, 1, 0, 0);
    send(8'h01, 0, 1);
    send(8'h02, 0, 0);
    send(8'h03, 0, 0);
    send(8'h04, 1, 0);

    // Backpressure: word held, input stalled, nothing lost on release
    @(posedge clk); #1;
    out_tready = 1'b0;
    expect_word(16'h5566, 0, 0, 0);
    expect_word(16'h7788, 1, 0, 0);
    send(8'h55, 0, 0);
    send(8'h66, 0, 0);
    check("stall_valid", out_tvalid, 1);
    check("stall_in_tready", in_tready, 0);
    fork
      begin
        send(8'h77, 0, 0);
        send(8'h88, 1, 0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_tdata", out_tdata, 16'h5566);
        end
        @(posedge clk); #1;
        out_tready = 1'b1;
      end
    join

    // Reset with a word pending clears the output at once
    @(posedge clk); #1;
    out_tready = 1'b0;
    send(8'hC1, 0, 0);
    send(8'hC2, 0, 0);
    check("pend_tdata", out_tdata, 16'hC1C2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tvalid", out_tvalid, 0);
    check("async_rst_tdata", out_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_tready = 1'b1;

    // Reset mid-word discards the partial byte
    send(8'h99, 0, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_word(16'hBEEF, 1, 0, 0);
    send(8'hBE, 0, 0);
    send(8'hEF, 1, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
